// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
//   state_e      : sequencer states
//   clog2        : elaboration-time ceil(log2) helper
//   DEF_*        : default geometry / widths
//   sat_add      : signed add clamped to a w-bit two's complement range
//                  (only referenced when SYSTOLIC_SAT_EN is defined)
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  localparam int DEF_ROWS  = 4;
  localparam int DEF_COLS  = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_K_MAX = 256;
  localparam int DEF_ACC_W = 2 * DEF_W + clog2(DEF_K_MAX);

  // Operands are sign-extended w-bit values carried in 64 bits, so the
  // 64-bit sum itself never overflows for w <= 62.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                 input logic signed [63:0] y,
                                                 input int w);
    logic signed [63:0] s, hi, lo;
    s  = x + y;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_pe.sv
// One output-stationary processing element.
//   a_in/b_in   : operands arriving from the left / above
//   a_out/b_out : registered copies passed right / down
//   acc         : running signed dot product
//   en, clr     : advance / clear (clr wins)
//   sat_flag    : this cycle's accumulate clamped (only with SYSTOLIC_SAT_EN)
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [W-1:0]     a_in,
  input  logic signed [W-1:0]     b_in,
  output logic signed [W-1:0]     a_out,
  output logic signed [W-1:0]     b_out,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat_flag
);

  logic signed [W-1:0]     a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, prod_ext;
  logic signed [2*W-1:0]   prod;
  logic                    sat_hit;

  always_comb begin
    prod     = (2*W)'(a_in) * (2*W)'(b_in);
    prod_ext = ACC_W'(prod);
  end

`ifdef SYSTOLIC_SAT_EN
  logic signed [63:0] sum_wide, sum_sat;
  always_comb begin
    sum_wide = 64'(acc_q) + 64'(prod_ext);
    sum_sat  = sat_add(64'(acc_q), 64'(prod_ext), ACC_W);
    acc_sum  = ACC_W'(sum_sat);
    sat_hit  = (sum_sat != sum_wide);
  end
`else
  always_comb begin
    acc_sum = acc_q + prod_ext;
    sat_hit = 1'b0;
  end
`endif

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sat_flag = 1'b0;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end else if (en) begin
      a_d      = a_in;
      b_d      = b_in;
      acc_d    = acc_sum;
      sat_flag = sat_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// ROWS x COLS output-stationary systolic matrix multiplier with sequencer.
// Computes C = A[ROWS][K] x B[K][COLS] from K operand beats.
//   start/k_len           : job launch (IDLE only), k_len clamped to K_MAX
//   in_valid/in_ready     : operand beat handshake (a_col_flat, b_row_flat)
//   out_valid/out_ready   : one result row per handshake (out_row, out_data)
//   out_last              : final row flag
//   busy, done, ovf       : status; ovf sticky per job
// Optional: SYSTOLIC_SAT_EN makes accumulators saturate and drive ovf;
// without it accumulators wrap and ovf stays 0.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int W     = DEF_W,
  parameter int K_MAX = DEF_K_MAX,
  parameter int ACC_W = 2 * W + clog2(K_MAX),
  parameter int KW    = clog2(K_MAX + 1),
  parameter int RW    = (clog2(ROWS) > 0) ? clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*W-1:0]     a_col_flat,
  input  logic [COLS*W-1:0]     b_row_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         out_row,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int FLUSH_N = ROWS + COLS - 2;
  localparam int FW      = clog2(ROWS + COLS) + 1;

  state_e          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d, kcnt_q, kcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d, ovf_q, ovf_d;
  logic            en, clr;
  logic [ROWS*COLS-1:0] sat_vec;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    kcnt_d  = kcnt_q;
    fcnt_d  = fcnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    ovf_d   = ovf_q | (|sat_vec);
    case (state_q)
      IDLE: if (start) begin
        clr     = 1'b1;
        ovf_d   = 1'b0;
        kcnt_d  = '0;
        row_d   = '0;
        klen_d  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        state_d = (k_len == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        // No beat: the whole array holds, keeping the skew alignment intact.
        en = in_valid;
        if (in_valid) begin
          if (kcnt_q == klen_q - KW'(1)) begin
            fcnt_d  = '0;
            state_d = (FLUSH_N == 0) ? DRAIN : FLUSH;
          end else begin
            kcnt_d = kcnt_q + KW'(1);
          end
        end
      end
      FLUSH: begin
        // Zeros push the last skewed terms through to the far corner PE.
        en = 1'b1;
        if (fcnt_q == FW'(FLUSH_N - 1)) state_d = DRAIN;
        else fcnt_d = fcnt_q + FW'(1);
      end
      DRAIN: if (out_ready) begin
        if (row_q == RW'(ROWS - 1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      kcnt_q  <= '0;
      fcnt_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      kcnt_q  <= kcnt_d;
      fcnt_q  <= fcnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == RW'(ROWS - 1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ovf       = ovf_q;

  // Skew: row i of A delayed i enabled cycles, column j of B delayed j.
  logic signed [W-1:0] a_lane [ROWS];
  logic signed [W-1:0] b_lane [COLS];

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic signed [W-1:0] a_feed;
    assign a_feed = (state_q == LOAD) ? a_col_flat[W*gi +: W] : '0;
    if (gi == 0) begin : g_direct
      assign a_lane[gi] = a_feed;
    end else begin : g_sr
      logic signed [W-1:0] sr_q [gi];
      logic signed [W-1:0] sr_d [gi];
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          for (int t = 0; t < gi; t++) sr_d[t] = '0;
        end else if (en) begin
          sr_d[0] = a_feed;
          for (int t = 1; t < gi; t++) sr_d[t] = sr_q[t-1];
        end
      end
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '{default: '0};
        else     sr_q <= sr_d;
      end
      assign a_lane[gi] = sr_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic signed [W-1:0] b_feed;
    assign b_feed = (state_q == LOAD) ? b_row_flat[W*gj +: W] : '0;
    if (gj == 0) begin : g_direct
      assign b_lane[gj] = b_feed;
    end else begin : g_sr
      logic signed [W-1:0] sr_q [gj];
      logic signed [W-1:0] sr_d [gj];
      always_comb begin
        sr_d = sr_q;
        if (clr) begin
          for (int t = 0; t < gj; t++) sr_d[t] = '0;
        end else if (en) begin
          sr_d[0] = b_feed;
          for (int t = 1; t < gj; t++) sr_d[t] = sr_q[t-1];
        end
      end
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '{default: '0};
        else     sr_q <= sr_d;
      end
      assign b_lane[gj] = sr_q[gj-1];
    end
  end

  logic signed [W-1:0]     a_pass [ROWS][COLS];
  logic signed [W-1:0]     b_pass [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_w  [ROWS][COLS];

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      logic signed [W-1:0] a_src, b_src;
      if (gc == 0) begin : g_al
        assign a_src = a_lane[gr];
      end else begin : g_ap
        assign a_src = a_pass[gr][gc-1];
      end
      if (gr == 0) begin : g_bl
        assign b_src = b_lane[gc];
      end else begin : g_bp
        assign b_src = b_pass[gr-1][gc];
      end
      systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .a_in     (a_src),
        .b_in     (b_src),
        .a_out    (a_pass[gr][gc]),
        .b_out    (b_pass[gr][gc]),
        .acc      (acc_w[gr][gc]),
        .sat_flag (sat_vec[gr*COLS+gc])
      );
    end
  end

  // Result row mux.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      out_data[ACC_W*c +: ACC_W] = acc_w[0][c];
      for (int r = 1; r < ROWS; r++) begin
        if (row_q == RW'(r)) out_data[ACC_W*c +: ACC_W] = acc_w[r][c];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
module tb_systolic_matmul_engine;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int AW = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [8:0]   k_len;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  a_col_flat;
  logic [31:0]  b_row_flat;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_row;
  logic [95:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         ovf;

  logic         s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [8:0]   s_k_len;
  logic [7:0]   s_a, s_b;
  logic [0:0]   s_out_row;
  logic [15:0]  s_out_data;
  logic         s_out_last, s_busy, s_done, s_ovf;

  always #5 clk = ~clk;

  systolic_matmul_engine #(.ROWS(4), .COLS(4), .W(8), .K_MAX(256)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col_flat(a_col_flat), .b_row_flat(b_row_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .ovf(ovf)
  );

  systolic_matmul_engine #(.ROWS(1), .COLS(1), .W(8), .K_MAX(256), .ACC_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_col_flat(s_a), .b_row_flat(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row),
    .out_data(s_out_data), .out_last(s_out_last),
    .busy(s_busy), .done(s_done), .ovf(s_ovf)
  );

  typedef struct packed {
    logic [1:0]  row;
    logic [95:0] data;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   expect_done = 1'b0;
  int   ma [4][4];
  int   mb [4][4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int r, input int v[4]);
    exp_t e;
    e.row  = 2'(r);
    e.data = '0;
    for (int j = 0; j < C; j++) e.data[AW*j +: AW] = v[j][AW-1:0];
    e.last = (r == R - 1);
    sbq.push_back(e);
  endtask

  task automatic push_zero_rows(input int from);
    for (int r = from; r < R; r++) push_row(r, '{0, 0, 0, 0});
  endtask

  task automatic push_model(input int k);
    int v[4];
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        v[c] = 0;
        for (int t = 0; t < k; t++) v[c] += ma[r][t] * mb[t][c];
      end
      push_row(r, v);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
  endtask

  task automatic set_beat(input int b);
    int v;
    for (int i = 0; i < R; i++) begin
      v = ma[i][b % 4];
      a_col_flat[8*i +: 8] = v[7:0];
    end
    for (int j = 0; j < C; j++) begin
      v = mb[b % 4][j];
      b_row_flat[8*j +: 8] = v[7:0];
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic run_job(input int klen, input int nbeats, input logic [15:0] vpat, input bit stall);
    int b, cyc, n;
    start = 1'b1;
    k_len = 9'(klen);
    tick();
    start = 1'b0;
    if (nbeats > 0) chk("in_ready_load", in_ready, 1);
    b = 0;
    cyc = 0;
    while (b < nbeats && cyc < 4 * nbeats + 16) begin
      in_valid = vpat[cyc % 16];
      if (in_valid) set_beat(b);
      else begin
        a_col_flat = 32'hA5A5A5A5;
        b_row_flat = 32'h5A5A5A5A;
      end
      tick();
      if (in_valid) b++;
      cyc++;
    end
    in_valid = 1'b0;
    if (nbeats > 0) begin
      chk("in_ready_flush", in_ready, 0);
      chk("busy_flush", busy, 1);
    end
    if (stall) begin
      n = 0;
      while (!(out_valid && out_row == 2'd1) && n < 100) begin
        tick();
        n++;
      end
      chk("stall_reach", out_valid && out_row == 2'd1, 1);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (s == 1) start = 1'b1;
        tick();
        start = 1'b0;
        chk("stall_valid", out_valid, 1);
        chk("stall_row", out_row, 1);
        chk("stall_data", out_data, (sbq.size() > 0) ? sbq[0].data : 96'h0);
      end
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  // Scoreboard monitor: pops one expected row per accepted result row.
  always @(negedge clk) begin
    exp_t e;
    if (expect_done) begin
      chk("done_pulse", done, 1);
      chk("valid_drop", out_valid, 0);
      expect_done = 1'b0;
    end
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row: got row %0d, expected none", out_row);
      end else begin
        e = sbq.pop_front();
        chk("row_idx", out_row, e.row);
        chk("row_data", out_data, e.data);
        chk("row_last", out_last, e.last);
        if (e.last) expect_done = 1'b1;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b1;
    a_col_flat = '0; b_row_flat = '0;
    s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick();

    // 2x2 example embedded in the top-left corner.
    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    push_row(0, '{19, 22, 0, 0});
    push_row(1, '{43, 50, 0, 0});
    push_zero_rows(2);
    run_job(2, 2, 16'hFFFF, 1'b0);

    // Signed extremes over three beats.
    clear_mats();
    for (int t = 0; t < 3; t++) begin
      ma[0][t] = -128;
      mb[t][0] = -128;
      mb[t][1] = 127;
    end
    push_row(0, '{49152, -48768, 0, 0});
    push_zero_rows(1);
    run_job(3, 3, 16'hFFFF, 1'b0);

    // Full 4x4 with gapped valid, row-1 backpressure and a stray start.
    ma = '{'{3, -7, 12, -1}, '{-128, 127, 5, 0}, '{9, -2, -33, 64}, '{1, 1, -1, 100}};
    mb = '{'{-5, 8, 2, 7}, '{11, -3, 0, -128}, '{6, 6, -6, 1}, '{127, -90, 4, -2}};
    push_model(4);
    run_job(4, 4, 16'h0059, 1'b1);
    tick();
    tick();
    chk("start_in_drain_ignored", busy, 0);

    // Zero-length job: all-zero result straight from DRAIN.
    push_zero_rows(0);
    run_job(0, 0, 16'h0000, 1'b0);

    // Reset in the middle of LOAD.
    start = 1'b1; k_len = 9'd4; tick(); start = 1'b0;
    in_valid = 1'b1; set_beat(0); tick(); set_beat(1); tick();
    rst = 1'b1; in_valid = 1'b0; tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();

    ma = '{'{2, 4, -6, 0}, '{0, -1, 1, 50}, '{-20, 3, 3, 3}, '{7, 0, 0, -9}};
    mb = '{'{1, -1, 2, 3}, '{10, 20, -30, 40}, '{0, 5, -5, 9}, '{0, 0, 0, 0}};
    push_model(3);
    run_job(3, 3, 16'hFFFF, 1'b0);

    // k_len beyond K_MAX runs exactly K_MAX beats.
    clear_mats();
    for (int t = 0; t < 4; t++) begin
      ma[0][t] = 1;
      mb[t][0] = 1;
    end
    push_row(0, '{256, 0, 0, 0});
    push_zero_rows(1);
    run_job(300, 256, 16'hFFFF, 1'b0);

    // 1x1, ACC_W=16: 4 x (127*127) overflows the accumulator.
    s_start = 1'b1; s_k_len = 9'd4; tick(); s_start = 1'b0;
    s_in_valid = 1'b1; s_a = 8'sd127; s_b = 8'sd127;
    repeat (4) tick();
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("sat_out_valid", s_out_valid, 1);
    chk("sat_out_last", s_out_last, 1);
`ifdef SYSTOLIC_SAT_EN
    chk("sat_value", s_out_data, 16'h7FFF);
    chk("sat_ovf", s_ovf, 1);
`else
    chk("wrap_value", s_out_data, 16'hFC04);
    chk("wrap_ovf", s_ovf, 0);
`endif
    s_out_ready = 1'b1;
    tick();
    chk("sat_done", s_done, 1);
    chk("sat_busy", s_busy, 0);
`ifdef SYSTOLIC_SAT_EN
    chk("sat_ovf_sticky", s_ovf, 1);
`else
    chk("wrap_ovf_after", s_ovf, 0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
